// File: rtl/exu_alu_cmt_fifo.sv
// Elastic in-order queue between the ALU result stage and commit.
// Discards in-flight entries on flush and freezes once an ebreak commits.
module exu_alu_cmt_fifo #(
  parameter int DEPTH      = 2,
  parameter int PC_SIZE    = 32,
  parameter int INSTR_SIZE = 32,
  parameter int XLEN       = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         alu_i_valid,
  output logic                         alu_i_ready,
  input  logic [PC_SIZE-1:0]           alu_i_pc,
  input  logic [INSTR_SIZE-1:0]        alu_i_instr,
  input  logic                         alu_i_pc_vld,
  input  logic [XLEN-1:0]              alu_i_imm,
  input  logic                         alu_i_bjp,
  input  logic                         alu_i_bjp_prdt,
  input  logic                         alu_i_ebreak,
  output logic                         cmt_o_valid,
  input  logic                         cmt_o_ready,
  output logic [PC_SIZE-1:0]           cmt_o_pc,
  output logic [INSTR_SIZE-1:0]        cmt_o_instr,
  output logic                         cmt_o_pc_vld,
  output logic [XLEN-1:0]              cmt_o_imm,
  output logic                         cmt_o_bjp,
  output logic                         cmt_o_bjp_prdt,
  output logic                         cmt_o_ebreak,
  output logic                         halted,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = PC_SIZE + INSTR_SIZE + XLEN + 4;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t         state;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [EW-1:0]  mem [DEPTH];
  logic [EW-1:0]  head;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Ready is independent of cmt_o_ready so commit back-pressure never reaches the ALU combinationally.
  assign alu_i_ready = !full && !halted && !flush;
  assign cmt_o_valid = !empty && !halted && !flush;
  assign push        = alu_i_valid && alu_i_ready;
  assign pop         = cmt_o_valid && cmt_o_ready;

  // Payload storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {alu_i_pc, alu_i_instr, alu_i_pc_vld, alu_i_imm,
                      alu_i_bjp, alu_i_bjp_prdt, alu_i_ebreak};
  end

  assign head = mem[rd_ptr];
  assign {cmt_o_pc, cmt_o_instr, cmt_o_pc_vld, cmt_o_imm,
          cmt_o_bjp, cmt_o_bjp_prdt, cmt_o_ebreak} = head;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_RUN;
      halted <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
          end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
            if (pop && cmt_o_ebreak) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end
          end
        end
        // Frozen until reset: entries, pointers and count are all held.
        S_HALT: begin
          state  <= S_HALT;
          halted <= 1'b1;
        end
        default: begin
          state  <= S_RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_exu_alu_cmt_fifo.sv
// Directed bench for exu_alu_cmt_fifo: ordering, streaming, simultaneous
// push/pop, flush, ebreak halt and asynchronous reset.
module tb_exu_alu_cmt_fifo;
  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        alu_i_valid;
  logic        alu_i_ready;
  logic [31:0] alu_i_pc;
  logic [31:0] alu_i_instr;
  logic        alu_i_pc_vld;
  logic [31:0] alu_i_imm;
  logic        alu_i_bjp;
  logic        alu_i_bjp_prdt;
  logic        alu_i_ebreak;
  logic        cmt_o_valid;
  logic        cmt_o_ready;
  logic [31:0] cmt_o_pc;
  logic [31:0] cmt_o_instr;
  logic        cmt_o_pc_vld;
  logic [31:0] cmt_o_imm;
  logic        cmt_o_bjp;
  logic        cmt_o_bjp_prdt;
  logic        cmt_o_ebreak;
  logic        halted;
  logic [1:0]  count;

  int tests = 0;
  int fails = 0;

  exu_alu_cmt_fifo #(.DEPTH(2), .PC_SIZE(32), .INSTR_SIZE(32), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alu_i_valid(alu_i_valid), .alu_i_ready(alu_i_ready),
    .alu_i_pc(alu_i_pc), .alu_i_instr(alu_i_instr), .alu_i_pc_vld(alu_i_pc_vld),
    .alu_i_imm(alu_i_imm), .alu_i_bjp(alu_i_bjp), .alu_i_bjp_prdt(alu_i_bjp_prdt),
    .alu_i_ebreak(alu_i_ebreak),
    .cmt_o_valid(cmt_o_valid), .cmt_o_ready(cmt_o_ready),
    .cmt_o_pc(cmt_o_pc), .cmt_o_instr(cmt_o_instr), .cmt_o_pc_vld(cmt_o_pc_vld),
    .cmt_o_imm(cmt_o_imm), .cmt_o_bjp(cmt_o_bjp), .cmt_o_bjp_prdt(cmt_o_bjp_prdt),
    .cmt_o_ebreak(cmt_o_ebreak),
    .halted(halted), .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] imm,
                       input logic bjp, input logic prdt, input logic ebrk);
    alu_i_valid    = v;
    alu_i_pc       = pc;
    alu_i_instr    = ~pc;
    alu_i_pc_vld   = 1'b1;
    alu_i_imm      = imm;
    alu_i_bjp      = bjp;
    alu_i_bjp_prdt = prdt;
    alu_i_ebreak   = ebrk;
  endtask

  task automatic test_reset;
    rst = 1'b0; flush = 1'b0; cmt_o_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick; tick;
    rst = 1'b1;
    mid;
    tests++; if (count !== 2'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
    tests++; if (alu_i_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", alu_i_ready); end
    tests++; if (cmt_o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", cmt_o_valid); end
    tests++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted got %b want 0", halted); end
    tick;
  endtask

  task automatic test_fill_drain;
    cmt_o_ready = 1'b0;
    drive(1'b1, 32'h8000_0000, 32'h0, 1'b0, 1'b0, 1'b0);
    mid; tick;
    drive(1'b1, 32'h8000_0004, 32'h0, 1'b0, 1'b0, 1'b0);
    mid;
    tests++; if (cmt_o_valid !== 1'b1 || cmt_o_pc !== 32'h8000_0000) begin fails++;
      $display("FAIL fill_first_visible got v=%b pc=%h want v=1 pc=80000000", cmt_o_valid, cmt_o_pc); end
    tick;
    alu_i_valid = 1'b0;
    mid;
    tests++; if (count !== 2'd2) begin fails++; $display("FAIL fill_count got %0d want 2", count); end
    tests++; if (alu_i_ready !== 1'b0) begin fails++; $display("FAIL fill_ready got %b want 0", alu_i_ready); end
    tick;
    cmt_o_ready = 1'b1;
    mid;
    tests++; if (cmt_o_valid !== 1'b1 || cmt_o_pc !== 32'h8000_0000) begin fails++;
      $display("FAIL drain_pop0 got v=%b pc=%h want v=1 pc=80000000", cmt_o_valid, cmt_o_pc); end
    tick; mid;
    tests++; if (cmt_o_valid !== 1'b1 || cmt_o_pc !== 32'h8000_0004 || count !== 2'd1) begin fails++;
      $display("FAIL drain_pop1 got v=%b pc=%h cnt=%0d want v=1 pc=80000004 cnt=1", cmt_o_valid, cmt_o_pc, count); end
    tick; mid;
    tests++; if (count !== 2'd0 || cmt_o_valid !== 1'b0) begin fails++;
      $display("FAIL drain_empty got cnt=%0d v=%b want cnt=0 v=0", count, cmt_o_valid); end
    tick;
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_pc;
    cmt_o_ready = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      drive(i < 16, 32'h0000_1000 + 32'(4 * i), 32'(i), 1'b0, 1'b0, 1'b0);
      mid;
      if (i == 0) begin
        tests++; if (count !== 2'd0 || cmt_o_valid !== 1'b0) begin fails++;
          $display("FAIL stream_start got cnt=%0d v=%b want cnt=0 v=0", count, cmt_o_valid); end
      end else begin
        exp_pc = 32'h0000_1000 + 32'(4 * (i - 1));
        tests++; if (cmt_o_valid !== 1'b1 || cmt_o_pc !== exp_pc || cmt_o_instr !== ~exp_pc || count !== 2'd1) begin fails++;
          $display("FAIL stream_pop%0d got v=%b pc=%h cnt=%0d want v=1 pc=%h cnt=1", i - 1, cmt_o_valid, cmt_o_pc, count, exp_pc); end
      end
      tick;
    end
    mid;
    tests++; if (count !== 2'd0 || cmt_o_valid !== 1'b0) begin fails++;
      $display("FAIL stream_end got cnt=%0d v=%b want cnt=0 v=0", count, cmt_o_valid); end
    tick;
  endtask

  task automatic test_simul_push_pop;
    cmt_o_ready = 1'b0;
    drive(1'b1, 32'h0000_2000, 32'h0000_0011, 1'b0, 1'b1, 1'b0);
    tick;
    drive(1'b1, 32'h0000_2004, 32'hFFFF_F800, 1'b1, 1'b0, 1'b0);
    tick;
    alu_i_valid = 1'b0;
    cmt_o_ready = 1'b1;
    mid;
    tests++; if (count !== 2'd2 || cmt_o_pc !== 32'h0000_2000 || cmt_o_bjp_prdt !== 1'b1) begin fails++;
      $display("FAIL simul_full got cnt=%0d pc=%h prdt=%b want cnt=2 pc=00002000 prdt=1", count, cmt_o_pc, cmt_o_bjp_prdt); end
    tick;
    drive(1'b1, 32'h0000_2008, 32'h0000_0123, 1'b0, 1'b0, 1'b0);
    mid;
    tests++; if (count !== 2'd1 || alu_i_ready !== 1'b1 || cmt_o_valid !== 1'b1) begin fails++;
      $display("FAIL simul_hs got cnt=%0d rdy=%b v=%b want cnt=1 rdy=1 v=1", count, alu_i_ready, cmt_o_valid); end
    tests++; if (cmt_o_pc !== 32'h0000_2004 || cmt_o_imm !== 32'hFFFF_F800 || cmt_o_bjp !== 1'b1 || cmt_o_bjp_prdt !== 1'b0) begin fails++;
      $display("FAIL simul_fields got pc=%h imm=%h bjp=%b prdt=%b want 00002004 fffff800 1 0", cmt_o_pc, cmt_o_imm, cmt_o_bjp, cmt_o_bjp_prdt); end
    tick;
    alu_i_valid = 1'b0;
    mid;
    tests++; if (count !== 2'd1 || cmt_o_pc !== 32'h0000_2008 || cmt_o_imm !== 32'h0000_0123) begin fails++;
      $display("FAIL simul_after got cnt=%0d pc=%h imm=%h want 1 00002008 00000123", count, cmt_o_pc, cmt_o_imm); end
    tick; mid;
    tests++; if (count !== 2'd0) begin fails++; $display("FAIL simul_drain got cnt=%0d want 0", count); end
    tick;
  endtask

  task automatic test_flush;
    cmt_o_ready = 1'b0;
    drive(1'b1, 32'h0000_3000, 32'h0, 1'b0, 1'b0, 1'b0);
    tick;
    drive(1'b1, 32'h0000_3004, 32'h0, 1'b0, 1'b0, 1'b0);
    tick;
    drive(1'b1, 32'h0000_3008, 32'h0, 1'b0, 1'b0, 1'b0);
    flush = 1'b1;
    cmt_o_ready = 1'b1;
    mid;
    tests++; if (alu_i_ready !== 1'b0 || cmt_o_valid !== 1'b0 || count !== 2'd2) begin fails++;
      $display("FAIL flush_cycle got rdy=%b v=%b cnt=%0d want rdy=0 v=0 cnt=2", alu_i_ready, cmt_o_valid, count); end
    tick;
    flush = 1'b0;
    alu_i_valid = 1'b0;
    mid;
    tests++; if (count !== 2'd0 || cmt_o_valid !== 1'b0) begin fails++;
      $display("FAIL flush_after got cnt=%0d v=%b want cnt=0 v=0", count, cmt_o_valid); end
    tick;
    drive(1'b1, 32'h0000_300C, 32'h0, 1'b0, 1'b0, 1'b0);
    tick;
    alu_i_valid = 1'b0;
    mid;
    tests++; if (cmt_o_valid !== 1'b1 || cmt_o_pc !== 32'h0000_300C || count !== 2'd1) begin fails++;
      $display("FAIL flush_next got v=%b pc=%h cnt=%0d want v=1 pc=0000300c cnt=1", cmt_o_valid, cmt_o_pc, count); end
    tick; mid;
    tests++; if (count !== 2'd0) begin fails++; $display("FAIL flush_drain got cnt=%0d want 0", count); end
    tick;
  endtask

  task automatic test_halt;
    cmt_o_ready = 1'b0;
    drive(1'b1, 32'h0000_4000, 32'h0, 1'b0, 1'b0, 1'b1);
    tick;
    drive(1'b1, 32'h0000_4004, 32'h0, 1'b0, 1'b0, 1'b0);
    tick;
    alu_i_valid = 1'b0;
    cmt_o_ready = 1'b1;
    mid;
    tests++; if (cmt_o_valid !== 1'b1 || cmt_o_ebreak !== 1'b1 || halted !== 1'b0) begin fails++;
      $display("FAIL halt_head got v=%b ebrk=%b halted=%b want 1 1 0", cmt_o_valid, cmt_o_ebreak, halted); end
    tick; mid;
    tests++; if (halted !== 1'b1 || cmt_o_valid !== 1'b0 || alu_i_ready !== 1'b0 || count !== 2'd1) begin fails++;
      $display("FAIL halt_state got halted=%b v=%b rdy=%b cnt=%0d want 1 0 0 1", halted, cmt_o_valid, alu_i_ready, count); end
    tick; mid;
    tests++; if (count !== 2'd1 || halted !== 1'b1) begin fails++;
      $display("FAIL halt_hold got cnt=%0d halted=%b want 1 1", count, halted); end
    tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    mid;
    tests++; if (halted !== 1'b1 || cmt_o_valid !== 1'b0) begin fails++;
      $display("FAIL halt_flush got halted=%b v=%b want 1 0", halted, cmt_o_valid); end
    tick;
    #2 rst = 1'b0;
    #1;
    tests++; if (halted !== 1'b0 || count !== 2'd0) begin fails++;
      $display("FAIL halt_reset got halted=%b cnt=%0d want 0 0", halted, count); end
    tick;
    rst = 1'b1;
    tick;
  endtask

  task automatic test_async_reset;
    cmt_o_ready = 1'b0;
    drive(1'b1, 32'h0000_5000, 32'h0, 1'b0, 1'b0, 1'b0);
    tick;
    drive(1'b1, 32'h0000_5004, 32'h0, 1'b0, 1'b0, 1'b0);
    tick;
    alu_i_valid = 1'b0;
    #1;
    tests++; if (count !== 2'd2 || cmt_o_valid !== 1'b1) begin fails++;
      $display("FAIL arst_pre got cnt=%0d v=%b want 2 1", count, cmt_o_valid); end
    #1 rst = 1'b0;
    #1;
    tests++; if (cmt_o_valid !== 1'b0 || count !== 2'd0) begin fails++;
      $display("FAIL arst_drop got v=%b cnt=%0d want 0 0", cmt_o_valid, count); end
    tick;
    rst = 1'b1;
    drive(1'b1, 32'h0000_5008, 32'h0000_0042, 1'b0, 1'b0, 1'b0);
    mid;
    tests++; if (alu_i_ready !== 1'b1) begin fails++; $display("FAIL arst_ready got %b want 1", alu_i_ready); end
    tick;
    alu_i_valid = 1'b0;
    cmt_o_ready = 1'b1;
    mid;
    tests++; if (cmt_o_valid !== 1'b1 || cmt_o_pc !== 32'h0000_5008 || cmt_o_imm !== 32'h0000_0042 || count !== 2'd1) begin fails++;
      $display("FAIL arst_new got v=%b pc=%h imm=%h cnt=%0d want 1 00005008 00000042 1", cmt_o_valid, cmt_o_pc, cmt_o_imm, count); end
    tick;
  endtask

  initial begin
    test_reset;
    test_fill_drain;
    test_back_to_back;
    test_simul_push_pop;
    test_flush;
    test_halt;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
